// File: rtl/hazard_detection_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use and ID-stage branch RAW hazards.
// Define HAZARD_PERF_CNT_EN to build the stall_cnt/flush_cnt performance counters.
module hazard_detection_unit #(
  parameter int REG_AW = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] IF_ID_r1,
  input  logic [REG_AW-1:0] IF_ID_r2,
  input  logic              IF_ID_UseR2,
  input  logic              IF_ID_branch,
  input  logic              branch_taken,
  input  logic [REG_AW-1:0] ID_EX_RegRd,
  input  logic              ID_EX_RegWrite,
  input  logic              ID_EX_MemRead,
  input  logic [REG_AW-1:0] EX_MEM_RegRd,
  input  logic              EX_MEM_MemRead,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic              ID_EX_Bubble,
  output logic              IF_ID_Flush,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t     state_r;
  logic [1:0] remain_r;
  logic [1:0] need_s;
  logic       stall_s;
  logic       flush_s;
  logic       exHit_s;
  logic       memHit_s;

  // Register 0 is hard-wired, so it never produces a hazard.
  function automatic logic mX(
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] r1,
    input logic [REG_AW-1:0] r2,
    input logic              useR2
  );
    return (rd != {REG_AW{1'b0}}) && ((rd == r1) || (useR2 && (rd == r2)));
  endfunction

  assign exHit_s  = mX(ID_EX_RegRd, IF_ID_r1, IF_ID_r2, IF_ID_UseR2);
  assign memHit_s = mX(EX_MEM_RegRd, IF_ID_r1, IF_ID_r2, IF_ID_UseR2);

  // Stall length required by the ID instruction; hazards are only looked at in RUN
  always_comb begin
    need_s = 2'd0;
    if (state_r == RUN) begin
      if (IF_ID_branch && ID_EX_MemRead && exHit_s) begin
        need_s = 2'd2;
      end else if (IF_ID_branch && ID_EX_RegWrite && exHit_s) begin
        need_s = 2'd1;
      end else if (IF_ID_branch && EX_MEM_MemRead && memHit_s) begin
        need_s = 2'd1;
      end else if (!IF_ID_branch && ID_EX_MemRead && exHit_s) begin
        need_s = 2'd1;
      end else begin
        need_s = 2'd0;
      end
    end else begin
      need_s = 2'd0;
    end
  end

  // Stall decision; reset forces the pipeline to run freely
  always_comb begin
    stall_s = 1'b0;
    if (!rst_n) begin
      stall_s = 1'b0;
    end else if (state_r == HOLD) begin
      stall_s = 1'b1;
    end else begin
      stall_s = (need_s != 2'd0);
    end
  end

  // A taken branch is only trusted once its operands are valid (no stall pending)
  always_comb begin
    flush_s = 1'b0;
    if (!rst_n) begin
      flush_s = 1'b0;
    end else begin
      flush_s = IF_ID_branch && branch_taken && !stall_s;
    end
  end

  assign PC_Write     = !stall_s;
  assign IF_ID_Write  = !stall_s;
  assign ID_EX_Bubble = stall_s;
  assign IF_ID_Flush  = flush_s;

  // RUN/HOLD sequencer so a two-cycle stall completes without re-detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r  <= RUN;
      remain_r <= 2'd0;
    end else begin
      case (state_r)
        RUN: begin
          if (need_s == 2'd2) begin
            remain_r <= 2'd1;
            state_r  <= HOLD;
          end else begin
            remain_r <= 2'd0;
            state_r  <= RUN;
          end
        end
        HOLD: begin
          remain_r <= remain_r - 2'd1;
          if (remain_r == 2'd1) begin
            state_r <= RUN;
          end else begin
            state_r <= HOLD;
          end
        end
        default: begin
          remain_r <= 2'd0;
          state_r  <= RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stallCnt_r;
  logic [CNT_W-1:0] flushCnt_r;

  // Free-running performance counters, wrapping naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stallCnt_r <= {CNT_W{1'b0}};
      flushCnt_r <= {CNT_W{1'b0}};
    end else begin
      if (stall_s) begin
        stallCnt_r <= stallCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (flush_s) begin
        flushCnt_r <= flushCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stall_cnt = stallCnt_r;
  assign flush_cnt = flushCnt_r;
`else
  assign stall_cnt = {CNT_W{1'b0}};
  assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Self-checking bench for hazard_detection_unit: directed scenarios plus randomized traffic
// compared against a stall-countdown reference model.
module tb_hazard_detection_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  IF_ID_r1, IF_ID_r2, ID_EX_RegRd, EX_MEM_RegRd;
  logic        IF_ID_UseR2, IF_ID_branch, branch_taken;
  logic        ID_EX_RegWrite, ID_EX_MemRead, EX_MEM_MemRead;
  logic        PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush;
  logic [31:0] stall_cnt, flush_cnt;

  int          nChecks = 0;
  int          nFails  = 0;

  // Reference model: number of forced stall cycles still owed, plus event totals.
  int          mOwed = 0;
  logic [31:0] mStalls = 32'd0;
  logic [31:0] mFlushes = 32'd0;
  logic        expStall, expFlush;
  logic [3:0]  expOut;
  logic [31:0] expSc, expFc;

  always #5 clk = ~clk;

  hazard_detection_unit #(.REG_AW(5), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .IF_ID_r1(IF_ID_r1), .IF_ID_r2(IF_ID_r2), .IF_ID_UseR2(IF_ID_UseR2),
    .IF_ID_branch(IF_ID_branch), .branch_taken(branch_taken),
    .ID_EX_RegRd(ID_EX_RegRd), .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .EX_MEM_RegRd(EX_MEM_RegRd), .EX_MEM_MemRead(EX_MEM_MemRead),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
    .IF_ID_Flush(IF_ID_Flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic bit hits(input logic [4:0] rd);
    return (rd != 5'd0) && ((rd == IF_ID_r1) || (IF_ID_UseR2 && (rd == IF_ID_r2)));
  endfunction

  function automatic int needOf();
    bit exHit  = hits(ID_EX_RegRd);
    bit memHit = hits(EX_MEM_RegRd);
    if (IF_ID_branch) begin
      if (ID_EX_MemRead && exHit)   return 2;
      if (ID_EX_RegWrite && exHit)  return 1;
      if (EX_MEM_MemRead && memHit) return 1;
      return 0;
    end
    return (ID_EX_MemRead && exHit) ? 1 : 0;
  endfunction

  task automatic evalModel();
    if (!rst_n) begin
      expStall = 1'b0;
      expFlush = 1'b0;
    end else begin
      expStall = (mOwed > 0) || (needOf() > 0);
      expFlush = IF_ID_branch && branch_taken && !expStall;
    end
    expOut = {!expStall, !expStall, expStall, expFlush};
`ifdef HAZARD_PERF_CNT_EN
    expSc = mStalls;
    expFc = mFlushes;
`else
    expSc = 32'd0;
    expFc = 32'd0;
`endif
  endtask

  // Clock edge plus model update; inputs are changed 1 time unit after the edge.
  task automatic advance();
    evalModel();
    @(posedge clk);
    if (!rst_n) begin
      mOwed = 0; mStalls = 32'd0; mFlushes = 32'd0;
    end else begin
      if (mOwed > 0) mOwed = mOwed - 1;
      else if (needOf() > 0) mOwed = needOf() - 1;
      if (expStall) mStalls = mStalls + 32'd1;
      if (expFlush) mFlushes = mFlushes + 32'd1;
    end
    #1;
  endtask

  task automatic clearInputs();
    IF_ID_r1 = 5'd0; IF_ID_r2 = 5'd0; IF_ID_UseR2 = 1'b0; IF_ID_branch = 1'b0;
    branch_taken = 1'b0; ID_EX_RegRd = 5'd0; ID_EX_RegWrite = 1'b0; ID_EX_MemRead = 1'b0;
    EX_MEM_RegRd = 5'd0; EX_MEM_MemRead = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clearInputs();
    ID_EX_MemRead = 1'b1; ID_EX_RegRd = 5'd9; IF_ID_r1 = 5'd9;
    advance(); advance();
    #3;
    nChecks++;
    if ({PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush} !== 4'b1100) begin
      nFails++; $display("FAIL reset_outputs: got %b want 1100", {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush});
    end
    nChecks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      nFails++; $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    advance();
    rst_n = 1'b1;
    clearInputs();
    advance();
  endtask

  // Directed single-scenario runner: each cycle's observed outputs are checked inline.
  task automatic test_load_use();
    ID_EX_MemRead = 1'b1; ID_EX_RegRd = 5'd5; IF_ID_r1 = 5'd5;
    #3; evalModel(); nChecks++;
    if ({PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush} !== 4'b0010 || expOut !== 4'b0010) begin
      nFails++; $display("FAIL load_use_stall: got %b want 0010", {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush});
    end
    advance();
    clearInputs(); IF_ID_r1 = 5'd5;
    #3; evalModel(); nChecks++;
    if ({PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush} !== 4'b1100) begin
      nFails++; $display("FAIL load_use_release: got %b want 1100", {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush});
    end
    nChecks++;
    if (stall_cnt !== expSc) begin
      nFails++; $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, expSc);
    end
    advance();
  endtask

  task automatic test_zero_and_user2();
    clearInputs(); ID_EX_MemRead = 1'b1; ID_EX_RegRd = 5'd0; IF_ID_r1 = 5'd0;
    #3; evalModel(); nChecks++;
    if (ID_EX_Bubble !== 1'b0 || PC_Write !== 1'b1) begin
      nFails++; $display("FAIL zero_reg: bubble=%b pcw=%b want 0/1", ID_EX_Bubble, PC_Write);
    end
    advance();
    clearInputs(); ID_EX_MemRead = 1'b1; ID_EX_RegRd = 5'd7; IF_ID_r2 = 5'd7; IF_ID_r1 = 5'd1;
    #3; evalModel(); nChecks++;
    if (ID_EX_Bubble !== 1'b0) begin
      nFails++; $display("FAIL user2_off: bubble=%b want 0", ID_EX_Bubble);
    end
    advance();
    IF_ID_UseR2 = 1'b1;
    #3; evalModel(); nChecks++;
    if ({PC_Write, IF_ID_Write, ID_EX_Bubble} !== 3'b001) begin
      nFails++; $display("FAIL user2_on: got %b want 001", {PC_Write, IF_ID_Write, ID_EX_Bubble});
    end
    advance();
    clearInputs();
    advance();
  endtask

  task automatic test_branch_after_load();
    logic [3:0] want [3];
    want[0] = 4'b0010; want[1] = 4'b0010; want[2] = 4'b1101;
    clearInputs();
    ID_EX_MemRead = 1'b1; ID_EX_RegRd = 5'd3; IF_ID_branch = 1'b1; IF_ID_r2 = 5'd3;
    IF_ID_UseR2 = 1'b1; branch_taken = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin ID_EX_MemRead = 1'b0; ID_EX_RegRd = 5'd0; end
      #3; evalModel(); nChecks++;
      if ({PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush} !== want[c] || expOut !== want[c]) begin
        nFails++; $display("FAIL branch_load c%0d: got %b want %b", c, {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush}, want[c]);
      end
      advance();
    end
    clearInputs();
    #3; evalModel(); nChecks++;
    if (stall_cnt !== expSc || flush_cnt !== expFc) begin
      nFails++; $display("FAIL branch_load_cnt: got %0d/%0d want %0d/%0d", stall_cnt, flush_cnt, expSc, expFc);
    end
    advance();
  endtask

  task automatic test_branch_after_alu();
    clearInputs();
    ID_EX_RegWrite = 1'b1; ID_EX_RegRd = 5'd4; IF_ID_branch = 1'b1; IF_ID_r1 = 5'd4;
    #3; evalModel(); nChecks++;
    if (ID_EX_Bubble !== 1'b1 || PC_Write !== 1'b0) begin
      nFails++; $display("FAIL branch_alu_stall: bubble=%b pcw=%b want 1/0", ID_EX_Bubble, PC_Write);
    end
    advance();
    ID_EX_RegWrite = 1'b0; ID_EX_RegRd = 5'd0;
    #3; evalModel(); nChecks++;
    if (ID_EX_Bubble !== 1'b0 || PC_Write !== 1'b1) begin
      nFails++; $display("FAIL branch_alu_release: bubble=%b pcw=%b want 0/1", ID_EX_Bubble, PC_Write);
    end
    advance();
  endtask

  task automatic test_reset_mid_hold();
    clearInputs();
    ID_EX_MemRead = 1'b1; ID_EX_RegRd = 5'd6; IF_ID_branch = 1'b1; IF_ID_r1 = 5'd6;
    advance();
    rst_n = 1'b0;
    #3; evalModel(); nChecks++;
    if ({PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush} !== 4'b1100) begin
      nFails++; $display("FAIL reset_hold_in: got %b want 1100", {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush});
    end
    advance();
    rst_n = 1'b1;
    clearInputs();
    #3; evalModel(); nChecks++;
    if ({PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush} !== 4'b1100 || stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      nFails++; $display("FAIL reset_hold_after: got %b cnt %0d/%0d want 1100 0/0",
                         {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush}, stall_cnt, flush_cnt);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n          = ($urandom_range(39, 0) != 0);
      IF_ID_r1       = 5'($urandom_range(3, 0));
      IF_ID_r2       = 5'($urandom_range(3, 0));
      IF_ID_UseR2    = 1'($urandom_range(1, 0));
      IF_ID_branch   = 1'($urandom_range(1, 0));
      branch_taken   = 1'($urandom_range(1, 0));
      ID_EX_RegRd    = 5'($urandom_range(3, 0));
      ID_EX_RegWrite = 1'($urandom_range(1, 0));
      ID_EX_MemRead  = 1'($urandom_range(1, 0));
      EX_MEM_RegRd   = 5'($urandom_range(3, 0));
      EX_MEM_MemRead = 1'($urandom_range(1, 0));
      #3; evalModel(); nChecks++;
      if ({PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush} !== expOut) begin
        nFails++; $display("FAIL random_out i=%0d: got %b want %b", i, {PC_Write, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush}, expOut);
      end
      nChecks++;
      if (stall_cnt !== expSc || flush_cnt !== expFc) begin
        nFails++; $display("FAIL random_cnt i=%0d: got %0d/%0d want %0d/%0d", i, stall_cnt, flush_cnt, expSc, expFc);
      end
      advance();
    end
    rst_n = 1'b1;
    clearInputs();
    advance(); advance();
  endtask

  initial begin
    rst_n = 1'b0;
    clearInputs();
    #1;
    test_reset();
    test_load_use();
    test_zero_and_user2();
    test_branch_after_load();
    test_branch_after_alu();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
